// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM states and the idle instruction word.
package inst_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // All-zero instruction driven when nothing is being issued; narrowed to IW at use.
  localparam logic [63:0] NOP = '0;

endpackage

// File: rtl/seq_prog_mem.sv
// Program buffer: DEPTH x IW, one synchronous write port, one asynchronous read port.
module seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int IW    = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [IW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [IW-1:0]            rdata
);

  logic [IW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/inst_sequencer.sv
// Loads a short program from a host, then issues it one instruction per cycle with an
// optional single hardware loop, honouring stall and pulsing done on completion.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_valid,
  input  logic [IW-1:0]            wr_data,
  output logic                     wr_ready,
  input  logic [$clog2(DEPTH)-1:0] loop_begin,
  input  logic [$clog2(DEPTH)-1:0] loop_end,
  input  logic [7:0]               loop_iters,
  input  logic                     start,
  input  logic                     stall,
  output logic [IW-1:0]            inst,
  output logic                     inst_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  seq_state_t    r_state, w_state_next;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_pc, r_lbeg, r_lend;
  logic [7:0]    r_rem;
  logic          r_loop_en, r_last;
  logic [IW-1:0] r_inst;
  logic          r_inst_valid, r_done;

  logic [IW-1:0] w_rdata;
  logic          w_wr_ready, w_wr_fire, w_clear, w_go, w_empty_go;
  logic          w_advance, w_finish, w_loop_back, w_at_end;

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr_fire),
    .waddr (r_count[AW-1:0]),
    .wdata (wr_data),
    .raddr (r_pc),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Clear takes priority over start when both arrive in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_wr_ready   = 1'b0;
    w_clear      = 1'b0;
    w_go         = 1'b0;
    w_empty_go   = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        w_wr_ready = (r_count < FULL) & ~start & ~clear;
        w_clear    = clear;
        if (start && !clear) begin
          if (r_count != '0) begin
            w_go         = 1'b1;
            w_state_next = RUN;
          end else begin
            w_empty_go = 1'b1;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          if (r_last) begin
            w_finish     = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_wr_fire   = wr_valid & w_wr_ready;
    w_loop_back = r_loop_en && (r_pc == r_lend) && (r_rem != '0);
    w_at_end    = ({1'b0, r_pc} == (r_count - (AW+1)'(1)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_pc         <= '0;
      r_rem        <= '0;
      r_lbeg       <= '0;
      r_lend       <= '0;
      r_loop_en    <= 1'b0;
      r_last       <= 1'b0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_clear) begin
        r_count <= '0;
      end else if (w_wr_fire) begin
        r_count <= r_count + (AW+1)'(1);
      end
      if (w_go) begin
        r_pc      <= '0;
        r_rem     <= loop_iters;
        r_lbeg    <= loop_begin;
        r_lend    <= loop_end;
        r_loop_en <= (loop_begin <= loop_end) && ({1'b0, loop_end} < r_count);
        r_last    <= 1'b0;
      end
      if (w_empty_go) begin
        r_done <= 1'b1;
      end
      if (w_advance) begin
        r_inst       <= w_rdata;
        r_inst_valid <= 1'b1;
        if (w_loop_back) begin
          r_pc  <= r_lbeg;
          r_rem <= r_rem - 8'd1;
        end else if (w_at_end) begin
          r_last <= 1'b1;
        end else begin
          r_pc <= r_pc + AW'(1);
        end
      end
      if (w_finish) begin
        r_inst       <= IW'(NOP);
        r_inst_valid <= 1'b0;
        r_done       <= 1'b1;
        r_last       <= 1'b0;
      end
    end
  end

  assign wr_ready   = w_wr_ready;
  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign busy       = (r_state == RUN);
  assign done       = r_done;
  assign count      = r_count;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: load, loop, stall, empty start, reset abort, full/clear.
module tb_inst_sequencer;

  localparam int DEPTH = 16;
  localparam int IW    = 32;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset, clear, wr_valid, start, stall;
  logic [IW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] loop_begin, loop_end;
  logic [7:0]    loop_iters;
  logic [IW-1:0] inst;
  logic          inst_valid, busy, done;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] prog[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs[$];
  int          valid_cycles, done_cyc, done_cnt, first_valid;

  inst_sequencer #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .loop_begin (loop_begin),
    .loop_end   (loop_end),
    .loop_iters (loop_iters),
    .start      (start),
    .stall      (stall),
    .inst       (inst),
    .inst_valid (inst_valid),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w);
    wr_valid = 1'b1;
    wr_data  = w;
    tick();
    wr_valid = 1'b0;
  endtask

  // Expected issue order: prefix up to loop_end, iters extra bodies, then the tail.
  task automatic build_expected(input int lb, input int le, input int it);
    int n;
    n = prog.size();
    exp_q.delete();
    if (lb > le || le >= n) begin
      foreach (prog[i]) exp_q.push_back(prog[i]);
    end else begin
      for (int i = 0; i <= le; i++) exp_q.push_back(prog[i]);
      for (int r = 0; r < it; r++)
        for (int i = lb; i <= le; i++) exp_q.push_back(prog[i]);
      for (int i = le + 1; i < n; i++) exp_q.push_back(prog[i]);
    end
  endtask

  task automatic run(input string tag, input int lb, input int le, input int it,
                     input int sf, input int sl, input int budget);
    build_expected(lb, le, it);
    loop_begin = AW'(lb);
    loop_end   = AW'(le);
    loop_iters = 8'(it);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check_eq({tag, "_busy"}, busy, 1);
    obs.delete();
    valid_cycles = 0;
    done_cyc     = -1;
    done_cnt     = 0;
    first_valid  = -1;
    for (int c = 1; c <= budget && done_cyc < 0; c++) begin
      stall = (c >= sf && c < sf + sl);
      tick();
      if (inst_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = c;
        if (!stall) obs.push_back(inst);
      end
      if (done) begin
        done_cyc = c;
        done_cnt++;
      end
    end
    stall = 1'b0;
    check_eq({tag, "_done_seen"}, (done_cyc >= 0), 1);
    check_eq({tag, "_first_valid"}, first_valid, 1);
    check_eq({tag, "_issues"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_inst%0d", tag, i), obs[i], exp_q[i]);
    tick();
    check_eq({tag, "_done_once"}, done, 0);
    check_eq({tag, "_idle_valid"}, inst_valid, 0);
    check_eq({tag, "_idle_inst"}, inst, 0);
    check_eq({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_data = '0; start = 1'b0; stall = 1'b0;
    loop_begin = '0; loop_end = '0; loop_iters = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_eq("rst_count", count, 0);
    check_eq("rst_valid", inst_valid, 0);
    check_eq("rst_inst", inst, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_wr_ready", wr_ready, 1);

    // Empty start: done the next cycle, nothing issued
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("empty_done", done, 1);
    check_eq("empty_valid", inst_valid, 0);
    check_eq("empty_busy", busy, 0);
    tick();
    check_eq("empty_done_clr", done, 0);
    check_eq("empty_valid2", inst_valid, 0);

    // Fibonacci program
    prog = '{32'h20010001, 32'h20020001, 32'h00210820};
    foreach (prog[i]) load(prog[i]);
    check_eq("fib_count", count, 3);
    run("fib", 2, 2, 9, 0, 0, 40);
    check_eq("fib_done_cyc", done_cyc, 13);
    check_eq("fib_valid_cycles", valid_cycles, 12);
    check_eq("fib_tail", obs.size() > 11 ? obs[11] : 32'h0, 32'h00210820);

    // Same buffer re-run with a 3-cycle stall during the 5th instruction
    run("stall", 2, 2, 9, 6, 3, 40);
    check_eq("stall_done_cyc", done_cyc, 16);
    check_eq("stall_valid_cycles", valid_cycles, 15);

    // Reset during the 3rd issue
    loop_begin = 4'd2; loop_end = 4'd2; loop_iters = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check_eq("abort_pre_inst", inst, 32'h00210820);
    reset = 1'b1;
    #1;
    check_eq("abort_valid", inst_valid, 0);
    check_eq("abort_count", count, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_inst", inst, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done || inst_valid) seen++;
    end
    check_eq("abort_quiet", seen, 0);

    // Reversed loop bounds: plain 4-instruction run
    prog = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    foreach (prog[i]) load(prog[i]);
    check_eq("bad_count", count, 4);
    run("badloop", 3, 1, 5, 0, 0, 40);
    check_eq("badloop_done_cyc", done_cyc, 5);
    check_eq("badloop_valid_cycles", valid_cycles, 4);

    // Loop end beyond the loaded program: loop disabled
    run("oorloop", 1, 5, 3, 0, 0, 40);
    check_eq("oorloop_done_cyc", done_cyc, 5);

    // Multi-instruction body with a tail
    run("body", 1, 2, 2, 0, 0, 40);
    check_eq("body_done_cyc", done_cyc, 9);

    // Clear ignored in RUN
    loop_begin = 4'd0; loop_end = 4'd0; loop_iters = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("run_clear_ignored", count, 4);
    for (int c = 0; c < 10 && busy; c++) tick();
    check_eq("run_clear_end", busy, 0);

    // Full buffer and clear-versus-write priority
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clear_count", count, 0);
    for (int i = 0; i < 16; i++) load(32'hA000_0000 + 32'(i));
    check_eq("full_count", count, 16);
    check_eq("full_wr_ready", wr_ready, 0);
    load(32'hDEADBEEF);
    check_eq("full_drop", count, 16);
    clear = 1'b1;
    wr_valid = 1'b1;
    wr_data = 32'hCAFEF00D;
    #1;
    check_eq("clear_wr_ready", wr_ready, 0);
    tick();
    clear = 1'b0;
    wr_valid = 1'b0;
    check_eq("clear_wins", count, 0);
    tick();
    check_eq("clear_hold", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, program-buffer entries (power of 2, >= 2).
REQ-002 SHALL have parameter IW, default 32, instruction width.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Ports, in order (name  direction  width  meaning):
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  empties the program buffer while IDLE.
- wr_valid  input  1  host write request.
- wr_data  input  IW  instruction to append.
- wr_ready  output  1  write accepted when wr_valid & wr_ready.
- loop_begin  input  log2(DEPTH)  first loop-body index, sampled at start.
- loop_end  input  log2(DEPTH)  last loop-body index, sampled at start.
- loop_iters  input  8  extra body repetitions, sampled at start.
- start  input  1  begin issuing the program.
- stall  input  1  hold current instruction.
- inst  output  IW  instruction presented to the cpu Inst port.
- inst_valid  output  1  inst is meaningful.
- busy  output  1  state is RUN.
- done  output  1  one-cycle completion pulse.
- count  output  log2(DEPTH)+1  entries loaded.

Function
REQ-005 SHALL implement two states: IDLE and RUN.
REQ-006 In IDLE: wr_ready = (count < DEPTH) & ~start & ~clear; an accepted write stores wr_data at index count; count increments.
REQ-007 clear in IDLE SHALL set count to 0 at the next edge; clear SHALL win over a same-cycle write; clear SHALL be ignored in RUN.
REQ-008 start in IDLE with count > 0 SHALL enter RUN, latch the loop configuration, set pc=0 and set rem=loop_iters.
REQ-009 start in IDLE with count == 0 SHALL pulse done for one cycle, stay in IDLE and issue nothing.
REQ-010 start and wr_valid SHALL be ignored in RUN; wr_ready=0 in RUN.
REQ-011 The loop SHALL be disabled for the run if loop_begin > loop_end or loop_end >= count.
REQ-012 At each RUN edge with stall=0: inst <= buf[pc] and inst_valid <= 1.
- If pc==loop_end, the loop is enabled and rem>0: pc <= loop_begin and rem decrements.
- Else if pc==count-1: mark last issued.
- Else: pc increments.
REQ-013 At the first RUN edge with stall=0 after the last instruction is issued: inst <= 0, inst_valid <= 0, done <= 1 for one cycle, state <= IDLE.
REQ-014 Latency: start sampled at edge n gives buf[0] on inst after edge n+1.
REQ-015 With no stall, total instructions issued SHALL equal count + loop_iters*(loop_end-loop_begin+1) when the loop is enabled, else count.
REQ-016 stall=1 SHALL hold inst, inst_valid, pc, rem and state unchanged; stall is ignored in IDLE.
REQ-017 In IDLE, inst=0 and inst_valid=0; busy = (state==RUN).
REQ-018 Buffer contents SHALL persist across runs until clear or reset, so a program re-runs on a new start.

Reset
REQ-019 reset SHALL asynchronously force IDLE, count=0, pc=0, rem=0, inst=0, inst_valid=0, done=0, busy=0.
REQ-020 reset in RUN SHALL abort the run without a done pulse; buffer contents become don't-care.

Structure
REQ-021 A shared package SHALL hold the state enum (IDLE, RUN) and the NOP constant (all zeros).
REQ-022 The buffer SHALL be one sub-module, seq_prog_mem: DEPTH x IW, one synchronous write port, one asynchronous read port.

Verification
REQ-023 Fibonacci: load 0x20010001, 0x20020001, 0x00210820; loop_begin=2, loop_end=2, loop_iters=9; start -> inst_valid high 12 consecutive cycles (two addi, then 10x 0x00210820), then done pulses once.
REQ-024 Stall: same program, stall=1 for 3 cycles during the 5th instruction -> 0x00210820 held 4 cycles; total 12 distinct issues; done delayed by 3 cycles.
REQ-025 Full/clear: 16 writes -> count=16, wr_ready=0, 17th write dropped; clear plus same-cycle wr_valid -> count=0, write dropped.
REQ-026 Empty start: count=0, start -> done pulse the next cycle; inst_valid never high.
REQ-027 Reset mid-run: assert reset during the 3rd issue -> immediate inst_valid=0, count=0, no done; a subsequent load/start behaves normally.
REQ-028 Bad loop: loop_begin=3, loop_end=1, loop_iters=5, count=4 -> exactly 4 instructions issued, in order.
